// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy dollar/quarter change payout engine with coin inventories
// Optional all-or-nothing payout when CHANGE_EXACT_EN is defined.
module change_dispenser #(
   parameter int PULSE_CYCLES  = 4,
   parameter int GAP_CYCLES    = 4,
   parameter int INIT_DOLLARS  = 15,
   parameter int INIT_QUARTERS = 15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [11:0] amount,
   input  logic        load_dollar,
   input  logic        load_quarter,
   output logic        dollar_out,
   output logic        quarter_out,
   output logic        busy,
   output logic        done,
   output logic [11:0] shortfall,
   output logic [3:0]  dollar_cnt,
   output logic [3:0]  quarter_cnt
);

   typedef enum logic [2:0] {IDLE, CHECK, SELECT, PULSE, GAP, DONE} state_t;

   state_t      state;
   logic [11:0] rem;
   logic [15:0] timer;
   logic        abort;
   logic        exact_fail;

`ifdef CHANGE_EXACT_EN
   logic [11:0] d_fit;
   logic [11:0] d_use;
   logic [11:0] r2;

   // Exact change needs the dollar-reduced residue to be whole quarters we actually hold.
   always_comb begin
      d_fit      = rem / 12'd100;
      d_use      = (d_fit > {8'd0, dollar_cnt}) ? {8'd0, dollar_cnt} : d_fit;
      r2         = rem - d_use * 12'd100;
      exact_fail = ((r2 % 12'd25) != 12'd0) || ((r2 / 12'd25) > {8'd0, quarter_cnt});
   end
`else
   assign exact_fail = 1'b0;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state       <= IDLE;
         rem         <= 12'd0;
         timer       <= 16'd0;
         abort       <= 1'b0;
         dollar_out  <= 1'b0;
         quarter_out <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         shortfall   <= 12'd0;
         dollar_cnt  <= 4'(INIT_DOLLARS);
         quarter_cnt <= 4'(INIT_QUARTERS);
      end else begin
         case (state)
            IDLE: begin
               if (load_dollar)  dollar_cnt  <= 4'd15;
               if (load_quarter) quarter_cnt <= 4'd15;
               if (start) begin
                  rem   <= amount;
                  abort <= 1'b0;
                  busy  <= 1'b1;
                  state <= CHECK;
               end
            end
            CHECK: begin
               abort <= exact_fail;
               state <= SELECT;
            end
            SELECT: begin
               if (!abort && rem >= 12'd100 && dollar_cnt != 4'd0) begin
                  rem        <= rem - 12'd100;
                  dollar_cnt <= dollar_cnt - 4'd1;
                  dollar_out <= 1'b1;
                  timer      <= 16'(PULSE_CYCLES - 1);
                  state      <= PULSE;
               end else if (!abort && rem >= 12'd25 && quarter_cnt != 4'd0) begin
                  rem         <= rem - 12'd25;
                  quarter_cnt <= quarter_cnt - 4'd1;
                  quarter_out <= 1'b1;
                  timer       <= 16'(PULSE_CYCLES - 1);
                  state       <= PULSE;
               end else begin
                  done      <= 1'b1;
                  shortfall <= rem;
                  state     <= DONE;
               end
            end
            PULSE: begin
               if (timer == 16'd0) begin
                  dollar_out  <= 1'b0;
                  quarter_out <= 1'b0;
                  timer       <= 16'(GAP_CYCLES - 1);
                  state       <= GAP;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            GAP: begin
               if (timer == 16'd0) state <= SELECT;
               else                timer <= timer - 16'd1;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser against a payout model
module tb_change_dispenser;

   localparam int P = 4;
   localparam int G = 4;
   localparam int COIN_T = 1 + P + G;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [11:0] amount;
   logic        load_dollar;
   logic        load_quarter;
   logic        dollar_out;
   logic        quarter_out;
   logic        busy;
   logic        done;
   logic [11:0] shortfall;
   logic [3:0]  dollar_cnt;
   logic [3:0]  quarter_cnt;

   int errors = 0;
   int checks = 0;

   int m_dc, m_qc, m_short;
   bit coin_is_dollar[64];
   int n_coins;

   change_dispenser #(
      .PULSE_CYCLES(P), .GAP_CYCLES(G), .INIT_DOLLARS(15), .INIT_QUARTERS(15)
   ) dut (
      .clk(clk), .clr(clr), .start(start), .amount(amount),
      .load_dollar(load_dollar), .load_quarter(load_quarter),
      .dollar_out(dollar_out), .quarter_out(quarter_out), .busy(busy), .done(done),
      .shortfall(shortfall), .dollar_cnt(dollar_cnt), .quarter_cnt(quarter_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Coin list, remaining inventory and shortfall from the payout rules applied directly.
   task automatic model(input int amt);
      int left;
      bit reject;
      left = amt;
      n_coins = 0;
      reject = 1'b0;
`ifdef CHANGE_EXACT_EN
      begin
         int d, r2;
         d  = (amt / 100 < m_dc) ? amt / 100 : m_dc;
         r2 = amt - 100 * d;
         reject = (r2 % 25 != 0) || (r2 / 25 > m_qc);
      end
`endif
      if (!reject) begin
         while (left >= 100 && m_dc > 0) begin
            left -= 100; m_dc--; coin_is_dollar[n_coins++] = 1'b1;
         end
         while (left >= 25 && m_qc > 0) begin
            left -= 25; m_qc--; coin_is_dollar[n_coins++] = 1'b0;
         end
      end
      m_short = left;
   endtask

   task automatic payout(input int amt, input bit ld_d, input bit ld_q, input bit poke);
      int t_done;
      bit exp_d, exp_q;
      if (ld_d) m_dc = 15;
      if (ld_q) m_qc = 15;
      model(amt);
      t_done = 2 + n_coins * COIN_T;
      @(negedge clk);
      start = 1'b1; amount = 12'(amt); load_dollar = ld_d; load_quarter = ld_q;
      @(negedge clk);
      start = 1'b0; load_dollar = 1'b0; load_quarter = 1'b0;
      for (int k = 0; k <= t_done + 1; k++) begin
         if (k > 0) @(negedge clk);
         if (poke && k == 5) begin
            start = 1'b1; load_dollar = 1'b1; load_quarter = 1'b1;
         end else begin
            start = 1'b0; load_dollar = 1'b0; load_quarter = 1'b0;
         end
         exp_d = 1'b0; exp_q = 1'b0;
         for (int j = 0; j < n_coins; j++) begin
            int r;
            r = 2 + j * COIN_T;
            if (k >= r && k < r + P) begin
               if (coin_is_dollar[j]) exp_d = 1'b1;
               else                   exp_q = 1'b1;
            end
         end
         check("dollar_out", 32'(dollar_out), 32'(exp_d));
         check("quarter_out", 32'(quarter_out), 32'(exp_q));
         check("busy", 32'(busy), 32'(k <= t_done));
         check("done", 32'(done), 32'(k == t_done));
      end
      check("shortfall", 32'(shortfall), 32'(m_short));
      check("dollar_cnt", 32'(dollar_cnt), 32'(m_dc));
      check("quarter_cnt", 32'(quarter_cnt), 32'(m_qc));
   endtask

   task automatic do_reset();
      clr = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      m_dc = 15; m_qc = 15; m_short = 0;
      @(negedge clk);
      check("rst_dollar_out", 32'(dollar_out), 32'd0);
      check("rst_quarter_out", 32'(quarter_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_shortfall", 32'(shortfall), 32'd0);
      check("rst_dollar_cnt", 32'(dollar_cnt), 32'd15);
      check("rst_quarter_cnt", 32'(quarter_cnt), 32'd15);
   endtask

   initial begin
      start = 1'b0; amount = 12'd0; load_dollar = 1'b0; load_quarter = 1'b0;
      do_reset();

      payout(125, 1'b0, 1'b0, 1'b0);
      payout(130, 1'b0, 1'b0, 1'b0);
      payout(0, 1'b0, 1'b0, 1'b0);
      payout(130, 1'b0, 1'b0, 1'b1);

      while (m_dc > 0) payout(100, 1'b0, 1'b0, 1'b0);
      payout(200, 1'b0, 1'b0, 1'b0);
      @(negedge clk); load_dollar = 1'b1;
      @(negedge clk); load_dollar = 1'b0; m_dc = 15;
      check("load_dollar_cnt", 32'(dollar_cnt), 32'd15);

      // Abort mid-pulse: outputs must fall without waiting for a clock edge.
      do_reset();
      @(negedge clk); start = 1'b1; amount = 12'd125;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_clr_dollar_out", 32'(dollar_out), 32'd1);
      #2 clr = 1'b1;
      #1;
      check("clr_dollar_out", 32'(dollar_out), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_dollar_cnt", 32'(dollar_cnt), 32'd15);
      check("clr_quarter_cnt", 32'(quarter_cnt), 32'd15);
      @(negedge clk); clr = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         check("clr_no_done", 32'(done), 32'd0);
      end

      // Dollars 0, quarters 3, then ask for one dollar.
      while (m_dc > 0) payout(100, 1'b0, 1'b0, 1'b0);
      payout(300, 1'b0, 1'b0, 1'b0);
      check("setup_quarters", 32'(quarter_cnt), 32'd3);
      payout(100, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         payout(int'($urandom_range(0, 700)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1) && (m_dc + m_qc > 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
